rans_enc_put_symbol: RTL and testbench

- Downstream consumer of the rANS encoder symbol-init stage.
- Captures the 256-entry per-symbol tables (x_max, rcp_freq, bias, cmpl_freq, rcp_shift) as the init stage streams them out.
- Encodes an incoming symbol stream with the reciprocal-multiply rANS update and emits renormalisation bytes, then the final state on flush.
- Symbols are supplied in reverse order, as rANS requires; the byte stream is reversed by the downstream packer.

---
 rtl/rans_enc_put_symbol_if.sv | 48 ++++
 rtl/rans_enc_put_symbol.sv | 184 ++++++++++++++++++
 tb/tb_rans_enc_put_symbol.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rans_enc_put_symbol_if.sv
// Table write streams plus symbol/byte handshakes between the rANS init stage,
// the symbol source and the byte packer.
`timescale 1ns/1ps
interface rans_enc_put_symbol_if #(
  parameter int DATAWIDTH_XMAX     = 18,
  parameter int DATAWIDTH_RCPFREQ  = 32,
  parameter int DATAWIDTH_BIAS     = 10,
  parameter int DATAWIDTH_CMPLFREQ = 9,
  parameter int DATAWIDTH_RCPSHIFT = 6
);
  logic                          tbl_clear;
  logic                          init_finish;
  logic [DATAWIDTH_XMAX-1:0]     x_max;
  logic                          x_max_valid;
  logic [DATAWIDTH_RCPFREQ-1:0]  rcp_freq;
  logic                          rcp_freq_valid;
  logic [DATAWIDTH_BIAS-1:0]     bias;
  logic                          bias_valid;
  logic [DATAWIDTH_CMPLFREQ-1:0] cmpl_freq;
  logic                          cmpl_freq_valid;
  logic [DATAWIDTH_RCPSHIFT-1:0] rcp_shift;
  logic                          rcp_shift_valid;
  logic                          tbl_loaded;
  logic                          sym_valid;
  logic                          sym_ready;
  logic [7:0]                    sym_data;
  logic                          sym_last;
  logic                          byte_valid;
  logic                          byte_ready;
  logic [7:0]                    byte_data;
  logic                          done;

  modport master (
    output tbl_clear, init_finish,
    output x_max, x_max_valid, rcp_freq, rcp_freq_valid, bias, bias_valid,
    output cmpl_freq, cmpl_freq_valid, rcp_shift, rcp_shift_valid,
    output sym_valid, sym_data, sym_last, byte_ready,
    input  tbl_loaded, sym_ready, byte_valid, byte_data, done
  );

  modport slave (
    input  tbl_clear, init_finish,
    input  x_max, x_max_valid, rcp_freq, rcp_freq_valid, bias, bias_valid,
    input  cmpl_freq, cmpl_freq_valid, rcp_shift, rcp_shift_valid,
    input  sym_valid, sym_data, sym_last, byte_ready,
    output tbl_loaded, sym_ready, byte_valid, byte_data, done
  );
endinterface

// File: rtl/rans_enc_put_symbol.sv
// rANS encoder put-symbol stage: captures the per-symbol tables, applies the
// reciprocal-multiply state update with byte renormalisation, flushes on last.
`timescale 1ns/1ps
module rans_enc_put_symbol #(
  parameter int DATAWIDTH_X        = 16,
  parameter int DATAWIDTH_XMAX     = 18,
  parameter int DATAWIDTH_RCPFREQ  = 32,
  parameter int DATAWIDTH_BIAS     = 10,
  parameter int DATAWIDTH_CMPLFREQ = 9,
  parameter int DATAWIDTH_RCPSHIFT = 6,
  parameter int RANS_BYTE_L_SHIFT  = 8
) (
  input logic                  clk,
  input logic                  rst,
  rans_enc_put_symbol_if.slave bus
);
  // state  | meaning
  // IDLE   | wait for symbol; LOOKUP | registered table read; RENORM | emit bytes while x >= x_max
  // MUL1-3 | reciprocal-multiply update of x; FLUSH | emit final x LSB first, then restart at L
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RENORM, S_MUL1, S_MUL2, S_MUL3, S_FLUSH
  } state_t;

  localparam int P_W     = DATAWIDTH_X + 32;
  localparam int N_FLUSH = DATAWIDTH_X / 8;
  localparam int CNT_W   = (N_FLUSH > 1) ? $clog2(N_FLUSH) : 1;
  localparam int CMP_W   = (DATAWIDTH_X > DATAWIDTH_XMAX) ? DATAWIDTH_X : DATAWIDTH_XMAX;
  localparam logic [DATAWIDTH_X-1:0] X_INIT = DATAWIDTH_X'(1) << RANS_BYTE_L_SHIFT;
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(N_FLUSH - 1);

  logic [DATAWIDTH_XMAX-1:0]     x_max_mem     [256];
  logic [DATAWIDTH_RCPFREQ-1:0]  rcp_freq_mem  [256];
  logic [DATAWIDTH_BIAS-1:0]     bias_mem      [256];
  logic [DATAWIDTH_CMPLFREQ-1:0] cmpl_freq_mem [256];
  logic [DATAWIDTH_RCPSHIFT-1:0] rcp_shift_mem [256];

  logic [7:0] ptr_x_max, ptr_rcp_freq, ptr_bias, ptr_cmpl_freq, ptr_rcp_shift;

  logic [DATAWIDTH_XMAX-1:0]     x_max_q;
  logic [DATAWIDTH_RCPFREQ-1:0]  rcp_freq_q;
  logic [DATAWIDTH_BIAS-1:0]     bias_q;
  logic [DATAWIDTH_CMPLFREQ-1:0] cmpl_freq_q;
  logic [DATAWIDTH_RCPSHIFT-1:0] rcp_shift_q;

  state_t                 state;
  logic [DATAWIDTH_X-1:0] x;
  logic [P_W-1:0]         p;
  logic [P_W-1:0]         q;
  logic [7:0]             sym_q;
  logic                   last_q;
  logic [CNT_W-1:0]       flush_cnt;
  logic                   tbl_loaded;
  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   done;

  logic                   sym_ready;
  logic                   need_renorm;
  logic [DATAWIDTH_X-1:0] qc_lo;
  logic [DATAWIDTH_X-1:0] x_upd;
  logic [DATAWIDTH_X-1:0] x_shr8;

  assign sym_ready   = (state == S_IDLE) && tbl_loaded;
  assign need_renorm = CMP_W'(x) >= CMP_W'(x_max_q);
  assign qc_lo       = DATAWIDTH_X'(q * P_W'(cmpl_freq_q));
  assign x_upd       = x + DATAWIDTH_X'(bias_q) + qc_lo;
  assign x_shr8      = x >> 8;

  assign bus.tbl_loaded = tbl_loaded;
  assign bus.sym_ready  = sym_ready;
  assign bus.byte_valid = byte_valid;
  assign bus.byte_data  = byte_data;
  assign bus.done       = done;

  // Each field is indexed only by its own pointer; tbl_clear drops a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst || bus.tbl_clear) begin
      ptr_x_max     <= 8'd0;
      ptr_rcp_freq  <= 8'd0;
      ptr_bias      <= 8'd0;
      ptr_cmpl_freq <= 8'd0;
      ptr_rcp_shift <= 8'd0;
    end else begin
      if (bus.x_max_valid)     ptr_x_max     <= ptr_x_max + 8'd1;
      if (bus.rcp_freq_valid)  ptr_rcp_freq  <= ptr_rcp_freq + 8'd1;
      if (bus.bias_valid)      ptr_bias      <= ptr_bias + 8'd1;
      if (bus.cmpl_freq_valid) ptr_cmpl_freq <= ptr_cmpl_freq + 8'd1;
      if (bus.rcp_shift_valid) ptr_rcp_shift <= ptr_rcp_shift + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.tbl_clear) begin
      if (bus.x_max_valid)     x_max_mem[ptr_x_max]         <= bus.x_max;
      if (bus.rcp_freq_valid)  rcp_freq_mem[ptr_rcp_freq]   <= bus.rcp_freq;
      if (bus.bias_valid)      bias_mem[ptr_bias]           <= bus.bias;
      if (bus.cmpl_freq_valid) cmpl_freq_mem[ptr_cmpl_freq] <= bus.cmpl_freq;
      if (bus.rcp_shift_valid) rcp_shift_mem[ptr_rcp_shift] <= bus.rcp_shift;
    end
    if (state == S_LOOKUP) begin
      x_max_q     <= x_max_mem[sym_q];
      rcp_freq_q  <= rcp_freq_mem[sym_q];
      bias_q      <= bias_mem[sym_q];
      cmpl_freq_q <= cmpl_freq_mem[sym_q];
      rcp_shift_q <= rcp_shift_mem[sym_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      x          <= X_INIT;
      p          <= '0;
      q          <= '0;
      sym_q      <= 8'd0;
      last_q     <= 1'b0;
      flush_cnt  <= '0;
      tbl_loaded <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.tbl_clear)        tbl_loaded <= 1'b0;
      else if (bus.init_finish) tbl_loaded <= 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.sym_valid && sym_ready) begin
            sym_q  <= bus.sym_data;
            last_q <= bus.sym_last;
            state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: state <= S_RENORM;
        S_RENORM: begin
          // Deassert after each renorm byte so the compare sees the shifted x.
          if (byte_valid) begin
            if (bus.byte_ready) begin
              byte_valid <= 1'b0;
              x          <= x_shr8;
            end
          end else if (need_renorm) begin
            byte_valid <= 1'b1;
            byte_data  <= x[7:0];
          end else begin
            state <= S_MUL1;
          end
        end
        S_MUL1: begin
          p     <= P_W'(x) * P_W'(rcp_freq_q);
          state <= S_MUL2;
        end
        S_MUL2: begin
          q     <= p >> rcp_shift_q;
          state <= S_MUL3;
        end
        S_MUL3: begin
          x         <= x_upd;
          flush_cnt <= '0;
          state     <= last_q ? S_FLUSH : S_IDLE;
        end
        S_FLUSH: begin
          if (!byte_valid) begin
            byte_valid <= 1'b1;
            byte_data  <= x[7:0];
          end else if (bus.byte_ready) begin
            if (flush_cnt == CNT_LAST) begin
              byte_valid <= 1'b0;
              done       <= 1'b1;
              x          <= X_INIT;
              state      <= S_IDLE;
            end else begin
              flush_cnt <= flush_cnt + CNT_W'(1);
              x         <= x_shr8;
              byte_data <= x_shr8[7:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rans_enc_put_symbol.sv
// Directed bench for rans_enc_put_symbol: table load, encodes with and without
// renormalisation, output stall, no-table lockout, mid-flush reset, table clear.
`timescale 1ns/1ps
module tb_rans_enc_put_symbol;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rans_enc_put_symbol_if bus ();

  rans_enc_put_symbol dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [17:0] f_xmax(input int i);
    if (i == 3) return 18'd32768;
    if (i == 7) return 18'd256;
    return 18'(i * 37 + 1);
  endfunction
  function automatic logic [31:0] f_rcp(input int i);
    if (i == 3) return 32'h8000_0000;
    if (i == 7) return 32'hFFFF_FFFF;
    return 32'(i) * 32'h0101_0101;
  endfunction
  function automatic logic [9:0] f_bias(input int i);
    if (i == 3) return 10'd0;
    if (i == 7) return 10'd260;
    return 10'(i);
  endfunction
  function automatic logic [8:0] f_cmpl(input int i);
    if (i == 3) return 9'd128;
    if (i == 7) return 9'd255;
    return 9'(i + 1);
  endfunction
  function automatic logic [5:0] f_shift(input int i);
    if (i == 3) return 6'd38;
    if (i == 7) return 6'd32;
    return 6'(i);
  endfunction

  task automatic send_sym(input logic [7:0] s, input logic last);
    int n = 0;
    while (!bus.sym_ready && n < 200) begin @(negedge clk); n++; end
    bus.sym_valid = 1'b1;
    bus.sym_data  = s;
    bus.sym_last  = last;
    @(negedge clk);
    bus.sym_valid = 1'b0;
  endtask

  // Returns X on timeout so the caller's comparison fails.
  task automatic get_byte(output logic [7:0] b);
    int n = 0;
    b = 'x;
    while (!bus.byte_valid && n < 200) begin @(negedge clk); n++; end
    if (bus.byte_valid) begin
      b = bus.byte_data;
      bus.byte_ready = 1'b1;
      @(negedge clk);
      bus.byte_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.tbl_loaded !== 1'b0) begin n_err++; $display("FAIL reset_tbl_loaded: got %b expected 0", bus.tbl_loaded); end
    n_vec++; if (bus.sym_ready !== 1'b0) begin n_err++; $display("FAIL reset_sym_ready: got %b expected 0", bus.sym_ready); end
    n_vec++; if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL reset_byte_valid: got %b expected 0", bus.byte_valid); end
    n_vec++; if (bus.byte_data !== 8'h00) begin n_err++; $display("FAIL reset_byte_data: got %h expected 00", bus.byte_data); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_vec++; if (dut.x !== 16'd256) begin n_err++; $display("FAIL reset_x: got %0d expected 256", dut.x); end
    n_vec++; if (dut.ptr_rcp_shift !== 8'd0) begin n_err++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr_rcp_shift); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_tables();
    int bad_ready = 0;
    int bad_byte  = 0;
    bus.sym_valid = 1'b1;
    bus.sym_data  = 8'd3;
    bus.sym_last  = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.sym_ready !== 1'b0) bad_ready++;
      if (bus.byte_valid !== 1'b0) bad_byte++;
    end
    bus.sym_valid = 1'b0;
    n_vec++; if (bad_ready !== 0) begin n_err++; $display("FAIL no_tables_sym_ready: got %0d cycles high expected 0", bad_ready); end
    n_vec++; if (bad_byte !== 0) begin n_err++; $display("FAIL no_tables_byte_valid: got %0d cycles high expected 0", bad_byte); end
  endtask

  task automatic test_load();
    for (int c = 0; c < 256 + 11; c++) begin
      bus.x_max_valid     = (c >= 0)  && (c < 256);
      bus.x_max           = bus.x_max_valid ? f_xmax(c) : '0;
      bus.rcp_freq_valid  = (c >= 3)  && (c < 259);
      bus.rcp_freq        = bus.rcp_freq_valid ? f_rcp(c - 3) : '0;
      bus.bias_valid      = (c >= 6)  && (c < 262);
      bus.bias            = bus.bias_valid ? f_bias(c - 6) : '0;
      bus.cmpl_freq_valid = (c >= 9)  && (c < 265);
      bus.cmpl_freq       = bus.cmpl_freq_valid ? f_cmpl(c - 9) : '0;
      bus.rcp_shift_valid = (c >= 11) && (c < 267);
      bus.rcp_shift       = bus.rcp_shift_valid ? f_shift(c - 11) : '0;
      @(negedge clk);
    end
    bus.x_max_valid = 0; bus.rcp_freq_valid = 0; bus.bias_valid = 0;
    bus.cmpl_freq_valid = 0; bus.rcp_shift_valid = 0;
    n_vec++; if (bus.tbl_loaded !== 1'b0) begin n_err++; $display("FAIL load_early_loaded: got %b expected 0", bus.tbl_loaded); end
    bus.init_finish = 1'b1;
    @(negedge clk);
    bus.init_finish = 1'b0;
    n_vec++; if (bus.tbl_loaded !== 1'b1) begin n_err++; $display("FAIL load_tbl_loaded: got %b expected 1", bus.tbl_loaded); end
    n_vec++; if (bus.sym_ready !== 1'b1) begin n_err++; $display("FAIL load_sym_ready: got %b expected 1", bus.sym_ready); end
    n_vec++; if (dut.ptr_x_max !== 8'd0) begin n_err++; $display("FAIL ptr_x_max_wrap: got %0d expected 0", dut.ptr_x_max); end
    n_vec++; if (dut.ptr_rcp_freq !== 8'd0) begin n_err++; $display("FAIL ptr_rcp_freq_wrap: got %0d expected 0", dut.ptr_rcp_freq); end
    n_vec++; if (dut.ptr_bias !== 8'd0) begin n_err++; $display("FAIL ptr_bias_wrap: got %0d expected 0", dut.ptr_bias); end
    n_vec++; if (dut.ptr_cmpl_freq !== 8'd0) begin n_err++; $display("FAIL ptr_cmpl_freq_wrap: got %0d expected 0", dut.ptr_cmpl_freq); end
    n_vec++; if (dut.ptr_rcp_shift !== 8'd0) begin n_err++; $display("FAIL ptr_rcp_shift_wrap: got %0d expected 0", dut.ptr_rcp_shift); end
    n_vec++; if (dut.rcp_freq_mem[200] !== 32'd200 * 32'h0101_0101) begin n_err++; $display("FAIL mem_rcp_200: got %h expected %h", dut.rcp_freq_mem[200], 32'd200 * 32'h0101_0101); end
    n_vec++; if (dut.rcp_shift_mem[255] !== 6'd63) begin n_err++; $display("FAIL mem_shift_255: got %0d expected 63", dut.rcp_shift_mem[255]); end
  endtask

  // x=256, sym 3: q = (256*2^31)>>38 = 2, x = 256 + 2*128 = 512, no renorm.
  task automatic test_sym3_flush();
    logic [7:0] b;
    send_sym(8'd3, 1'b1);
    get_byte(b);
    n_vec++; if (b !== 8'h00) begin n_err++; $display("FAIL sym3_byte0: got %h expected 00", b); end
    get_byte(b);
    n_vec++; if (b !== 8'h02) begin n_err++; $display("FAIL sym3_byte1: got %h expected 02", b); end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL sym3_done: got %b expected 1", bus.done); end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL sym3_done_pulse: got %b expected 0", bus.done); end
    n_vec++; if (bus.sym_ready !== 1'b1) begin n_err++; $display("FAIL sym3_ready_after: got %b expected 1", bus.sym_ready); end
  endtask

  // x=256 >= 256 -> renorm 0x00, x=1; q=0, x = 1 + 260 = 0x105.
  task automatic test_sym7_renorm_stall();
    logic [7:0] b;
    int n = 0;
    int bad = 0;
    send_sym(8'd7, 1'b1);
    while (!bus.byte_valid && n < 50) begin @(negedge clk); n++; end
    n_vec++; if (bus.byte_valid !== 1'b1) begin n_err++; $display("FAIL stall_first_valid: got %b expected 1", bus.byte_valid); end
    repeat (10) begin
      @(negedge clk);
      if (bus.byte_valid !== 1'b1 || bus.byte_data !== 8'h00 || bus.sym_ready !== 1'b0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
    get_byte(b);
    n_vec++; if (b !== 8'h00) begin n_err++; $display("FAIL sym7_renorm: got %h expected 00", b); end
    get_byte(b);
    n_vec++; if (b !== 8'h05) begin n_err++; $display("FAIL sym7_byte0: got %h expected 05", b); end
    get_byte(b);
    n_vec++; if (b !== 8'h01) begin n_err++; $display("FAIL sym7_byte1: got %h expected 01", b); end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL sym7_done: got %b expected 1", bus.done); end
    @(negedge clk);
  endtask

  // 3 then 7: x 256 -> 512; 512 renorms 0x00 -> 2; q=1, x = 2+260+255 = 0x205.
  // Then 3,3: x 256 -> 512 -> 1024 = 0x400.
  task automatic test_back_to_back();
    logic [7:0] b;
    int lat = 0;
    int stray = 0;
    send_sym(8'd3, 1'b0);
    while (!bus.sym_ready && lat < 50) begin
      if (bus.byte_valid !== 1'b0) stray++;
      @(negedge clk);
      lat++;
    end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL latency: got %0d cycles expected 5", lat); end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL latency_stray_byte: got %0d expected 0", stray); end
    send_sym(8'd7, 1'b1);
    get_byte(b);
    n_vec++; if (b !== 8'h00) begin n_err++; $display("FAIL b2b_renorm: got %h expected 00", b); end
    get_byte(b);
    n_vec++; if (b !== 8'h05) begin n_err++; $display("FAIL b2b_byte0: got %h expected 05", b); end
    get_byte(b);
    n_vec++; if (b !== 8'h02) begin n_err++; $display("FAIL b2b_byte1: got %h expected 02", b); end
    @(negedge clk);
    send_sym(8'd3, 1'b0);
    send_sym(8'd3, 1'b1);
    get_byte(b);
    n_vec++; if (b !== 8'h00) begin n_err++; $display("FAIL b2b33_byte0: got %h expected 00", b); end
    get_byte(b);
    n_vec++; if (b !== 8'h04) begin n_err++; $display("FAIL b2b33_byte1: got %h expected 04", b); end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b33_done: got %b expected 1", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_flush();
    logic [7:0] b;
    int dn = 0;
    send_sym(8'd3, 1'b1);
    get_byte(b);
    n_vec++; if (b !== 8'h00) begin n_err++; $display("FAIL midrst_byte0: got %h expected 00", b); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL midrst_byte_valid: got %b expected 0", bus.byte_valid); end
    n_vec++; if (bus.tbl_loaded !== 1'b0) begin n_err++; $display("FAIL midrst_tbl_loaded: got %b expected 0", bus.tbl_loaded); end
    repeat (4) begin
      if (bus.done !== 1'b0) dn++;
      @(negedge clk);
    end
    n_vec++; if (dn !== 0) begin n_err++; $display("FAIL midrst_done: got %0d pulses expected 0", dn); end
    bus.init_finish = 1'b1;
    @(negedge clk);
    bus.init_finish = 1'b0;
    send_sym(8'd3, 1'b1);
    get_byte(b);
    n_vec++; if (b !== 8'h00) begin n_err++; $display("FAIL midrst_rerun0: got %h expected 00", b); end
    get_byte(b);
    n_vec++; if (b !== 8'h02) begin n_err++; $display("FAIL midrst_rerun1: got %h expected 02", b); end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL midrst_rerun_done: got %b expected 1", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_tbl_clear();
    bus.x_max_valid = 1'b1;
    bus.x_max       = 18'd7;
    @(negedge clk);
    bus.tbl_clear = 1'b1;
    bus.x_max     = 18'h3FFFF;
    @(negedge clk);
    bus.tbl_clear   = 1'b0;
    bus.x_max_valid = 1'b0;
    n_vec++; if (dut.ptr_x_max !== 8'd0) begin n_err++; $display("FAIL clear_ptr: got %0d expected 0", dut.ptr_x_max); end
    n_vec++; if (dut.x_max_mem[1] !== f_xmax(1)) begin n_err++; $display("FAIL clear_write_dropped: got %h expected %h", dut.x_max_mem[1], f_xmax(1)); end
    n_vec++; if (dut.x_max_mem[0] !== 18'd7) begin n_err++; $display("FAIL loaded_write_accepted: got %h expected 7", dut.x_max_mem[0]); end
    n_vec++; if (bus.tbl_loaded !== 1'b0) begin n_err++; $display("FAIL clear_tbl_loaded: got %b expected 0", bus.tbl_loaded); end
    n_vec++; if (bus.sym_ready !== 1'b0) begin n_err++; $display("FAIL clear_sym_ready: got %b expected 0", bus.sym_ready); end
  endtask

  initial begin
    bus.tbl_clear = 0; bus.init_finish = 0;
    bus.x_max = '0; bus.x_max_valid = 0; bus.rcp_freq = '0; bus.rcp_freq_valid = 0;
    bus.bias = '0; bus.bias_valid = 0; bus.cmpl_freq = '0; bus.cmpl_freq_valid = 0;
    bus.rcp_shift = '0; bus.rcp_shift_valid = 0;
    bus.sym_valid = 0; bus.sym_data = '0; bus.sym_last = 0; bus.byte_ready = 0;
    @(negedge clk);
    test_reset();
    test_no_tables();
    test_load();
    test_sym3_flush();
    test_sym7_renorm_stall();
    test_back_to_back();
    test_reset_mid_flush();
    test_tbl_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
